// File: rtl/board_pkg.sv
// board_pkg: shared cell codes, colour selects and win-state type for the board renderer
package board_pkg;
    localparam logic [1:0] EMPTY = 2'd0, P1 = 2'd1, P2 = 2'd2;
    localparam logic [2:0] COLOR_BLACK = 3'b000, COLOR_WHITE = 3'b111, COLOR_RED = 3'b100, COLOR_GREEN = 3'b010;
    typedef enum logic {IDLE, FLASH} win_state_t;
endpackage

// File: rtl/frame_phase_timer.sv
// frame_phase_timer: counts frame ticks and toggles phase every PERIOD ticks; phase 0 = on
module frame_phase_timer #(
    parameter int PERIOD = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic phase
);
    localparam int CW = PERIOD > 1 ? $clog2(PERIOD) : 1;
    logic [CW-1:0] cnt;
    logic wrap;
    always_comb wrap = cnt == CW'(PERIOD - 1);
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
            phase <= 1'b0;
        end else if (tick) begin
            cnt <= wrap ? '0 : cnt + CW'(1);
            phase <= wrap ? ~phase : phase;
        end
    end
endmodule

// File: rtl/board_renderer.sv
// board_renderer: two-stage pixel colour pipeline for an N x N board with marks, cursor and win flash
module board_renderer
    import board_pkg::*;
#(
    parameter int N = 3,
    parameter int CELL = 160,
    parameter int LINE_W = 20,
    parameter int MARK_C = 70,
    parameter int MARK_HALF = 50,
    parameter int CURSOR_HALF = 10,
    parameter int COLOR_W = 10,
    parameter int BLINK_FR = 30,
    parameter int FLASH_FR = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_valid,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               frame_start,
    input  logic [2:0]         cursor_row,
    input  logic [2:0]         cursor_col,
    input  logic [2*N*N-1:0]   cells,
    input  logic               win_valid,
    input  logic [N*N-1:0]     win_mask,
    output logic               out_valid,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue
);
    logic [2*N*N-1:0] snap, cells_eff;
    logic [N*N-1:0] snap_mask, mask_eff;
    logic [N-1:0] mx, my;
    logic [1:0] code, code1;
    logic [2:0] sel;
    logic lx, ly, in_board, cur_hit, masked;
    logic v1, line1, cur1, mask1, blink_phase, flash_phase;
    int xi, yi, ccx, ccy;
    win_state_t state;
    always_comb begin
        xi = int'(x);
        yi = int'(y);
        cells_eff = frame_start ? cells : snap;
        mask_eff = frame_start ? win_mask : snap_mask;
        lx = 1'b0;
        ly = 1'b0;
        for (int k = 1; k < N; k++) begin
            lx |= xi >= k*CELL - LINE_W + 1 && xi <= k*CELL - 1;
            ly |= yi >= k*CELL - LINE_W + 1 && yi <= k*CELL - 1;
        end
        for (int i = 0; i < N; i++) begin
            mx[i] = xi > i*CELL + MARK_C - MARK_HALF && xi < i*CELL + MARK_C + MARK_HALF;
            my[i] = yi > i*CELL + MARK_C - MARK_HALF && yi < i*CELL + MARK_C + MARK_HALF;
        end
        code = EMPTY;
        masked = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (mx[c] && my[r]) begin
                    code = cells_eff[2*(r*N+c) +: 2];
                    masked = mask_eff[r*N+c];
                end
        ccx = int'(cursor_col) * CELL + MARK_C;
        ccy = int'(cursor_row) * CELL + MARK_C;
        in_board = xi < N*CELL && yi < N*CELL;
        cur_hit = int'(cursor_row) < N && int'(cursor_col) < N &&
                  xi > ccx - CURSOR_HALF && xi < ccx + CURSOR_HALF &&
                  yi > ccy - CURSOR_HALF && yi < ccy + CURSOR_HALF;
        sel = !v1 ? COLOR_BLACK :
              line1 ? COLOR_WHITE :
              (cur1 && !blink_phase) ? COLOR_WHITE :
              code1 == EMPTY ? COLOR_BLACK :
              (state == FLASH && mask1 && !flash_phase) ? COLOR_WHITE :
              code1 == P1 ? COLOR_RED : COLOR_GREEN;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            snap <= '0;
            snap_mask <= '0;
            state <= IDLE;
            v1 <= 1'b0;
            line1 <= 1'b0;
            cur1 <= 1'b0;
            code1 <= EMPTY;
            mask1 <= 1'b0;
            out_valid <= 1'b0;
            red <= '0;
            green <= '0;
            blue <= '0;
        end else begin
            if (frame_start) begin
                snap <= cells;
                snap_mask <= win_mask;
            end
            state <= state == IDLE ? ((frame_start && win_valid) ? FLASH : IDLE) : (win_valid ? FLASH : IDLE);
            v1 <= pix_valid;
            line1 <= in_board && (lx || ly);
            cur1 <= in_board && cur_hit;
            code1 <= (code == P1 || code == P2) ? code : EMPTY;
            mask1 <= masked;
            out_valid <= v1;
            red <= {COLOR_W{sel[2]}};
            green <= {COLOR_W{sel[1]}};
            blue <= {COLOR_W{sel[0]}};
        end
    end
    frame_phase_timer #(.PERIOD(BLINK_FR)) u_blink (
        .clk(clk), .reset(reset), .clear(1'b0), .tick(frame_start), .phase(blink_phase)
    );
    // flash timer is held cleared outside FLASH so entry always starts at count 0, phase on
    frame_phase_timer #(.PERIOD(FLASH_FR)) u_flash (
        .clk(clk), .reset(reset), .clear(state == IDLE || !win_valid), .tick(frame_start), .phase(flash_phase)
    );
endmodule
